// File: rtl/lc3_mem_ctrl_if.sv
// External memory request/acknowledge bus used by the LC3 memory controller.
// The controller is the master; the memory (or a bench model) is the slave.
interface lc3_mem_ctrl_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC3 memory/IO access sequencer: owns MAR/MDR, handshakes with external memory
// under a timeout watchdog, and implements the keyboard and display registers.
module lc3_mem_ctrl #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [15:0] KBSR_ADDR = 16'hFE00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           DATABUS,
    input  logic                  LD_MAR,
    input  logic                  LD_MDR,
    input  logic                  MIO_EN,
    input  logic                  R_W,
    input  logic                  GateMDR,
    inout  wire  [15:0]           MDRbus_out,
    output logic                  R,
    output logic                  mem_err,
    lc3_mem_ctrl_if.master        mem,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_data,
    output logic                  kb_ready,
    output logic                  kb_irq,
    output logic [7:0]            dsp_data,
    output logic                  dsp_valid,
    input  logic                  dsp_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [15:0] KBDR_ADDR   = KBSR_ADDR + 16'd2;
    localparam logic [15:0] DSR_ADDR    = KBSR_ADDR + 16'd4;
    localparam logic [15:0] DDR_ADDR    = KBSR_ADDR + 16'd6;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        kbsr15_q, kbsr15_d;
    logic        kbsr14_q, kbsr14_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        dsr15_q, dsr15_d;
    logic [7:0]  dsp_data_q, dsp_data_d;
    logic        dsp_valid_q, dsp_valid_d;

    logic is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;

    assign is_kbsr = (mar_q == KBSR_ADDR);
    assign is_kbdr = (mar_q == KBDR_ADDR);
    assign is_dsr  = (mar_q == DSR_ADDR);
    assign is_ddr  = (mar_q == DDR_ADDR);
    assign is_dev  = is_kbsr | is_kbdr | is_dsr | is_ddr;

    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        kbsr15_d    = kbsr15_q;
        kbsr14_d    = kbsr14_q;
        kbdr_d      = kbdr_q;
        dsr15_d     = dsr15_q;
        dsp_data_d  = dsp_data_q;
        dsp_valid_d = dsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (LD_MAR) begin
                    mar_d = DATABUS;
                end
                if (MIO_EN) begin
                    op_d = R_W;
                    if (is_dev) begin
                        state_d = S_DONE;
                        if (is_kbsr) begin
                            if (R_W) kbsr14_d = mdr_q[14];
                            else     mdr_d    = {kbsr15_q, kbsr14_q, 14'b0};
                        end else if (is_kbdr) begin
                            if (!R_W) begin
                                mdr_d    = {8'b0, kbdr_q};
                                kbsr15_d = 1'b0;
                            end
                        end else if (is_dsr) begin
                            if (!R_W) mdr_d = {dsr15_q, 15'b0};
                        end else begin
                            if (!R_W) begin
                                mdr_d = 16'h0000;
                            end else if (dsr15_q) begin
                                dsp_data_d  = mdr_q[7:0];
                                dsp_valid_d = 1'b1;
                                dsr15_d     = 1'b0;
                            end
                        end
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = 8'd0;
                    end
                end else if (LD_MDR) begin
                    mdr_d = DATABUS;
                end
            end
            S_ACCESS: begin
                // An ack arriving on the final allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    if (!op_q) mdr_d = mem.mem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_d = 1'b1;
                    if (!op_q) mdr_d = 16'h0000;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Evaluated after the register ops so a new keystroke beats a KBDR-read clear.
        if (kb_valid && !kbsr15_q) begin
            kbdr_d   = kb_data;
            kbsr15_d = 1'b1;
        end

        if (dsp_valid_q && dsp_ack) begin
            dsp_valid_d = 1'b0;
            dsr15_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mar_q       <= 16'h0000;
            mdr_q       <= 16'h0000;
            op_q        <= 1'b0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            kbsr15_q    <= 1'b0;
            kbsr14_q    <= 1'b0;
            kbdr_q      <= 8'h00;
            dsr15_q     <= 1'b1;
            dsp_data_q  <= 8'h00;
            dsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            kbsr15_q    <= kbsr15_d;
            kbsr14_q    <= kbsr14_d;
            kbdr_q      <= kbdr_d;
            dsr15_q     <= dsr15_d;
            dsp_data_q  <= dsp_data_d;
            dsp_valid_q <= dsp_valid_d;
        end
    end

    assign R             = (state_q == S_DONE);
    assign mem.mem_req   = (state_q == S_ACCESS);
    assign mem.mem_we    = (state_q == S_ACCESS) && op_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign mem_err       = err_q;
    assign kb_ready      = ~kbsr15_q;
    assign kb_irq        = kbsr15_q & kbsr14_q;
    assign dsp_data      = dsp_data_q;
    assign dsp_valid     = dsp_valid_q;
    assign MDRbus_out    = GateMDR ? mdr_q : 16'hzzzz;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: a transaction-level model predicts each
// access result, and a monitor checks it whenever the DUT pulses R.
module tb_lc3_mem_ctrl;

    localparam int TMO = 4;

    typedef struct {
        logic [15:0] mdr;
        logic        err;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] DATABUS;
    logic        LD_MAR, LD_MDR, MIO_EN, R_W, GateMDR;
    wire  [15:0] mdr_bus;
    logic        R, mem_err;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready, kb_irq;
    logic [7:0]  dsp_data;
    logic        dsp_valid, dsp_ack;

    lc3_mem_ctrl_if mem_if ();

    lc3_mem_ctrl #(.TIMEOUT(TMO), .KBSR_ADDR(16'hFE00)) dut (
        .clk        (clk),
        .reset      (reset),
        .DATABUS    (DATABUS),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .MIO_EN     (MIO_EN),
        .R_W        (R_W),
        .GateMDR    (GateMDR),
        .MDRbus_out (mdr_bus),
        .R          (R),
        .mem_err    (mem_err),
        .mem        (mem_if),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .kb_irq     (kb_irq),
        .dsp_data   (dsp_data),
        .dsp_valid  (dsp_valid),
        .dsp_ack    (dsp_ack)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    exp_t exp_q[$];

    // Reference model state, kept at the level of "what the programmer sees".
    logic [15:0] ref_mdr;
    logic        ref_err;
    logic        kb_full, kb_ie;
    logic [7:0]  kb_char;
    logic        dsp_free, dsp_pending;
    logic [7:0]  dsp_char;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ext_mem [logic [15:0]];

    // Memory responder controls
    int          ack_delay  = 0;
    int          req_cycles = 0;
    logic        exp_we;
    logic [15:0] exp_addr, exp_wdata;

    function automatic logic [15:0] memDefault(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // External memory: acks after ack_delay request cycles (0 = never).
    always @(negedge clk) begin
        if (mem_if.mem_req) begin
            req_cycles++;
            if (ack_delay != 0 && req_cycles == ack_delay) begin
                mem_if.mem_ack = 1'b1;
                checkOutput("mem_addr", mem_if.mem_addr, exp_addr);
                checkOutput("mem_we", mem_if.mem_we, exp_we);
                if (mem_if.mem_we) begin
                    checkOutput("mem_wdata", mem_if.mem_wdata, exp_wdata);
                    ext_mem[mem_if.mem_addr] = mem_if.mem_wdata;
                end else begin
                    mem_if.mem_rdata = ext_mem.exists(mem_if.mem_addr) ?
                                       ext_mem[mem_if.mem_addr] : memDefault(mem_if.mem_addr);
                end
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = 16'($urandom);
            end
        end else begin
            mem_if.mem_ack = 1'b0;
        end
    end

    // Monitor: every R pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (R) begin
            if (exp_q.size() == 0) begin
                checkOutput("R_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("R_mdr", mem_if.mem_wdata, e.mdr);
                checkOutput("R_err", mem_err, e.err);
                checkOutput("R_cycles", req_cycles, e.cycles);
            end
        end
    end

    task automatic modelReset();
        ref_mdr = 16'h0000; ref_err = 1'b0;
        kb_full = 1'b0; kb_ie = 1'b0; kb_char = 8'h00;
        dsp_free = 1'b1; dsp_pending = 1'b0; dsp_char = 8'h00;
    endtask

    // One complete access; key >= 0 offers a keystroke on the MIO_EN cycle.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                                 input int delay, input int key);
        exp_t e;
        logic old_full;
        bit   seen;
        @(posedge clk); #1;
        DATABUS = addr; LD_MAR = 1'b1;
        if (we) begin
            @(posedge clk); #1;
            LD_MAR = 1'b0; DATABUS = wdata; LD_MDR = 1'b1;
            ref_mdr = wdata;
        end
        @(posedge clk); #1;
        LD_MAR = 1'b0; LD_MDR = 1'b0;

        e.cycles = 0;
        old_full = kb_full;
        case (addr)
            16'hFE00: if (we) kb_ie = ref_mdr[14]; else ref_mdr = {kb_full, kb_ie, 14'b0};
            16'hFE02: if (!we) begin ref_mdr = {8'h00, kb_char}; kb_full = 1'b0; end
            16'hFE04: if (!we) ref_mdr = dsp_free ? 16'h8000 : 16'h0000;
            16'hFE06: begin
                if (!we) ref_mdr = 16'h0000;
                else if (dsp_free) begin
                    dsp_char = ref_mdr[7:0]; dsp_pending = 1'b1; dsp_free = 1'b0;
                end
            end
            default: begin
                if (delay == 0) begin
                    ref_err  = 1'b1;
                    e.cycles = TMO + 1;
                    if (!we) ref_mdr = 16'h0000;
                end else begin
                    e.cycles = delay;
                    if (we) ref_mem[addr] = ref_mdr;
                    else    ref_mdr = ref_mem.exists(addr) ? ref_mem[addr] : memDefault(addr);
                end
            end
        endcase
        if (key >= 0 && !old_full) begin
            kb_full = 1'b1; kb_char = key[7:0];
        end
        e.mdr = ref_mdr;
        e.err = ref_err;
        exp_q.push_back(e);

        exp_we = we; exp_addr = addr; exp_wdata = ref_mdr;
        ack_delay = delay; req_cycles = 0;
        R_W = we; MIO_EN = 1'b1;
        if (key >= 0) begin kb_valid = 1'b1; kb_data = key[7:0]; end
        @(posedge clk); #1;
        MIO_EN = 1'b0; kb_valid = 1'b0;

        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (R) seen = 1;
        end
        if (!seen) begin
            checkOutput("R_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
    endtask

    task automatic checkPeriph(input string tag);
        @(negedge clk);
        checkOutput({tag, "_kb_ready"}, kb_ready, !kb_full);
        checkOutput({tag, "_kb_irq"}, kb_irq, kb_full & kb_ie);
        checkOutput({tag, "_dsp_valid"}, dsp_valid, dsp_pending);
        checkOutput({tag, "_dsp_data"}, dsp_data, dsp_char);
    endtask

    task automatic checkBus();
        @(posedge clk); #1; GateMDR = 1'b1;
        @(negedge clk);
        checkOutput("bus_drive", mdr_bus, ref_mdr);
        @(posedge clk); #1; GateMDR = 1'b0;
        @(negedge clk);
        if (ref_mdr != 16'h0000)
            checkOutput("bus_release", (mdr_bus === 16'hzzzz || mdr_bus === 16'h0000), 1'b1);
    endtask

    task automatic keyPress(input logic [7:0] ch);
        @(posedge clk); #1; kb_valid = 1'b1; kb_data = ch;
        @(posedge clk); #1; kb_valid = 1'b0;
        if (!kb_full) begin kb_full = 1'b1; kb_char = ch; end
    endtask

    task automatic dspAck();
        @(posedge clk); #1; dsp_ack = 1'b1;
        @(posedge clk); #1; dsp_ack = 1'b0;
        if (dsp_pending) begin dsp_pending = 1'b0; dsp_free = 1'b1; end
    endtask

    task automatic randomAccess();
        logic [15:0] a;
        int          d, k;
        if ($urandom_range(0, 9) < 6) a = 16'(16'h3000 + $urandom_range(0, 7));
        else                          a = 16'(16'hFE00 + 2 * $urandom_range(0, 3));
        d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 1);
        k = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : -1;
        if ($urandom_range(0, 3) == 0) keyPress(8'($urandom));
        if ($urandom_range(0, 2) == 0) dspAck();
        applyStimulus(a, 1'($urandom_range(0, 1)), 16'($urandom), d, k);
        checkPeriph("rand");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; DATABUS = 16'h0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
        GateMDR = 0; kb_valid = 0; kb_data = 8'h0; dsp_ack = 0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 16'h0;
        modelReset();
        ext_mem[16'h3000] = 16'hBEEF;
        ref_mem[16'h3000] = 16'hBEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_R", R, 1'b0);
        checkOutput("rst_mem_req", mem_if.mem_req, 1'b0);
        checkOutput("rst_mem_we", mem_if.mem_we, 1'b0);
        checkOutput("rst_mem_err", mem_err, 1'b0);
        checkOutput("rst_mar", mem_if.mem_addr, 16'h0000);
        checkOutput("rst_mdr", mem_if.mem_wdata, 16'h0000);
        checkPeriph("rst");
        reset = 1'b1;

        $display("[TB] reset DSR read");
        applyStimulus(16'hFE04, 1'b0, 16'h0, 0, -1);
        checkBus();

        $display("[TB] memory read / write");
        applyStimulus(16'h3000, 1'b0, 16'h0, 3, -1);
        checkBus();
        applyStimulus(16'h4000, 1'b1, 16'h1234, 2, -1);
        applyStimulus(16'h4000, 1'b0, 16'h0, 1, -1);
        applyStimulus(16'h3001, 1'b0, 16'h0, TMO + 1, -1);

        $display("[TB] random phase 1");
        for (int i = 0; i < 40; i++) randomAccess();

        $display("[TB] timeout");
        applyStimulus(16'h5000, 1'b0, 16'h0, 0, -1);
        applyStimulus(16'h3000, 1'b0, 16'h0, 1, -1);
        checkOutput("err_sticky", mem_err, 1'b1);

        $display("[TB] keyboard");
        keyPress(8'h41);
        checkPeriph("kb1");
        keyPress(8'h42);
        checkPeriph("kb2");
        applyStimulus(16'hFE02, 1'b0, 16'h0, 0, -1);
        checkPeriph("kb3");
        applyStimulus(16'hFE00, 1'b1, 16'h4000, 0, -1);
        checkPeriph("kb4");
        keyPress(8'h43);
        checkPeriph("kb5");
        applyStimulus(16'hFE00, 1'b0, 16'h0, 0, -1);
        applyStimulus(16'hFE02, 1'b0, 16'h0, 0, -1);
        applyStimulus(16'hFE02, 1'b0, 16'h0, 0, 16'h44);
        checkPeriph("kb6");
        applyStimulus(16'hFE02, 1'b0, 16'h0, 0, -1);
        checkPeriph("kb7");

        $display("[TB] display");
        applyStimulus(16'hFE06, 1'b1, 16'h0058, 0, -1);
        checkPeriph("dsp1");
        applyStimulus(16'hFE04, 1'b0, 16'h0, 0, -1);
        applyStimulus(16'hFE06, 1'b1, 16'h0077, 0, -1);
        checkPeriph("dsp2");
        applyStimulus(16'hFE06, 1'b0, 16'h0, 0, -1);
        dspAck();
        checkPeriph("dsp3");
        applyStimulus(16'hFE04, 1'b0, 16'h0, 0, -1);

        $display("[TB] random phase 2");
        for (int i = 0; i < 20; i++) randomAccess();

        $display("[TB] reset during access");
        @(posedge clk); #1; DATABUS = 16'h6000; LD_MAR = 1'b1;
        @(posedge clk); #1; LD_MAR = 1'b0; ack_delay = 0; req_cycles = 0; R_W = 1'b0; MIO_EN = 1'b1;
        @(posedge clk); #1; MIO_EN = 1'b0;
        @(negedge clk);
        checkOutput("abort_req_active", mem_if.mem_req, 1'b1);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("abort_req_dropped", mem_if.mem_req, 1'b0);
        checkOutput("abort_err_cleared", mem_err, 1'b0);
        checkOutput("abort_mdr", mem_if.mem_wdata, 16'h0000);
        repeat (10) @(negedge clk);
        checkPeriph("abort");
        applyStimulus(16'hFE04, 1'b0, 16'h0, 0, -1);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
